// File: rtl/data_mem_responder.sv
// data_mem_responder: data memory on the far side of the processor data port.
// Serves processor reads/writes (registered read, read-first), host preloads,
// and on the processor's done pulse streams the result region [R_START..R_END]
// out over a valid/ready dump port.
// Optional build macro DUMP_LANE_SPLIT_EN: emit each word as CORE_COUNT
// single-lane beats (highest lane first) instead of one full-width beat.
module data_mem_responder #(
  parameter int REG_WIDTH           = 12,
  parameter int CORE_COUNT          = 3,
  parameter int DATA_MEM_DEPTH      = 4096,
  parameter int DATA_MEM_ADDR_WIDTH = 12,
  parameter int R_START_LOC         = 5,
  parameter int R_END_LOC           = 8,
  localparam int DATA_MEM_WIDTH     = REG_WIDTH * CORE_COUNT
) (
  input  logic                           clk,
  input  logic                           rstN,
  input  logic [DATA_MEM_ADDR_WIDTH-1:0] dataMemAddr,
  input  logic [DATA_MEM_WIDTH-1:0]      ProcessorDataOut,
  input  logic                           DataMemWrEn,
  output logic [DATA_MEM_WIDTH-1:0]      ProcessorDataIn,
  input  logic                           done,
  input  logic                           loadEn,
  input  logic [DATA_MEM_ADDR_WIDTH-1:0] loadAddr,
  input  logic [DATA_MEM_WIDTH-1:0]      loadData,
  output logic [DATA_MEM_WIDTH-1:0]      dumpData,
  output logic [DATA_MEM_ADDR_WIDTH-1:0] dumpAddr,
  output logic                           dumpValid,
  input  logic                           dumpReady,
  output logic                           dumpLast,
  output logic                           busy,
  output logic                           dumpDone
);

  localparam int AW = DATA_MEM_ADDR_WIDTH;
  localparam int DW = DATA_MEM_WIDTH;
  localparam logic [AW-1:0] START_LOC_A = AW'(R_START_LOC);
  localparam logic [AW-1:0] END_LOC_A   = AW'(R_END_LOC);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_START, S_RD_END, S_RD_WORD, S_PRESENT, S_FINISH
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   mem [DATA_MEM_DEPTH];
  logic [DW-1:0]   pdi_q;
  logic [DW-1:0]   word_q;
  logic [AW-1:0]   start_q, end_q;
  logic [AW:0]     ptr_q;      // one extra bit so endAddr = DEPTH-1 cannot wrap
  logic [AW-1:0]   word_rd_addr;
  logic            word_rd_en;
  logic [AW-1:0]   bound_w;
  logic            last_word;

`ifdef DUMP_LANE_SPLIT_EN
  localparam int LANE_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(CORE_COUNT - 1);
  logic [LANE_W-1:0] lane_q;
`endif

  // Lane 0 of a memory word interpreted as an address; wider bounds truncate.
  function automatic logic [AW-1:0] lane0_addr(input logic [DW-1:0] w);
    logic [AW-1:0] a;
    a = '0;
    for (int i = 0; i < AW; i++) begin
      if (i < REG_WIDTH) a[i] = w[i];
    end
    return a;
  endfunction

  assign bound_w   = lane0_addr(word_q);
  assign last_word = (ptr_q == {1'b0, end_q});

  // Dump-side read address: bound locations are fetched one cycle ahead so the
  // word is already in word_q when RD_START/RD_END evaluate it.
  always_comb begin
    word_rd_addr = ptr_q[AW-1:0];
    word_rd_en   = 1'b0;
    case (state_q)
      S_IDLE:     begin word_rd_addr = START_LOC_A;     word_rd_en = 1'b1; end
      S_RD_START: begin word_rd_addr = END_LOC_A;       word_rd_en = 1'b1; end
      S_RD_WORD:  begin word_rd_addr = ptr_q[AW-1:0];   word_rd_en = 1'b1; end
      default:    begin word_rd_addr = ptr_q[AW-1:0];   word_rd_en = 1'b0; end
    endcase
  end

  // Storage: writes only in IDLE, load port wins; read-first dump-side read port.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE) begin
      if (loadEn)           mem[loadAddr]    <= loadData;
      else if (DataMemWrEn) mem[dataMemAddr] <= ProcessorDataOut;
    end
    if (word_rd_en) word_q <= mem[word_rd_addr];
  end

  // State register plus dump bookkeeping and the processor read register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= S_IDLE;
      pdi_q   <= '0;
      start_q <= '0;
      end_q   <= '0;
      ptr_q   <= '0;
`ifdef DUMP_LANE_SPLIT_EN
      lane_q  <= LAST_LANE;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE) pdi_q <= mem[dataMemAddr];
      if (state_q == S_RD_START) start_q <= bound_w;
      if (state_q == S_RD_END) begin
        end_q <= bound_w;
        ptr_q <= {1'b0, start_q};
`ifdef DUMP_LANE_SPLIT_EN
        lane_q <= LAST_LANE;
`endif
      end
      if (state_q == S_PRESENT && dumpReady) begin
`ifdef DUMP_LANE_SPLIT_EN
        if (lane_q != '0) begin
          lane_q <= lane_q - 1'b1;
        end else begin
          lane_q <= LAST_LANE;
          ptr_q  <= ptr_q + 1'b1;
        end
`else
        ptr_q <= ptr_q + 1'b1;
`endif
      end
    end
  end

  // Next-state logic for the dump sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (done) state_d = S_RD_START;
      S_RD_START: state_d = S_RD_END;
      S_RD_END:   state_d = (bound_w < start_q) ? S_FINISH : S_RD_WORD;
      S_RD_WORD:  state_d = S_PRESENT;
      S_PRESENT: begin
        if (dumpReady) begin
`ifdef DUMP_LANE_SPLIT_EN
          if (lane_q != '0)   state_d = S_PRESENT;
          else if (last_word) state_d = S_FINISH;
          else                state_d = S_RD_WORD;
`else
          state_d = last_word ? S_FINISH : S_RD_WORD;
`endif
        end
      end
      S_FINISH:   state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; dump payload is zero outside PRESENT.
  always_comb begin
    ProcessorDataIn = pdi_q;
    dumpValid       = (state_q == S_PRESENT);
    dumpAddr        = '0;
    dumpData        = '0;
    dumpLast        = 1'b0;
    busy            = (state_q == S_RD_START) || (state_q == S_RD_END) ||
                      (state_q == S_RD_WORD)  || (state_q == S_PRESENT);
    dumpDone        = (state_q == S_FINISH);
    if (state_q == S_PRESENT) begin
      dumpAddr = ptr_q[AW-1:0];
`ifdef DUMP_LANE_SPLIT_EN
      dumpData = DW'(word_q[int'(lane_q)*REG_WIDTH +: REG_WIDTH]);
      dumpLast = last_word && (lane_q == '0);
`else
      dumpData = word_q;
      dumpLast = last_word;
`endif
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder (default full-width dump build).
module tb_data_mem_responder;

  localparam int AW = 12;
  localparam int DW = 36;

  logic          clk = 1'b0;
  logic          rstN = 1'b1;
  logic [AW-1:0] dataMemAddr = '0;
  logic [DW-1:0] ProcessorDataOut = '0;
  logic          DataMemWrEn = 1'b0;
  logic [DW-1:0] ProcessorDataIn;
  logic          done = 1'b0;
  logic          loadEn = 1'b0;
  logic [AW-1:0] loadAddr = '0;
  logic [DW-1:0] loadData = '0;
  logic [DW-1:0] dumpData;
  logic [AW-1:0] dumpAddr;
  logic          dumpValid;
  logic          dumpReady = 1'b0;
  logic          dumpLast;
  logic          busy;
  logic          dumpDone;

  int n_cmp = 0;
  int n_bad = 0;

  data_mem_responder dut (
    .clk(clk), .rstN(rstN),
    .dataMemAddr(dataMemAddr), .ProcessorDataOut(ProcessorDataOut),
    .DataMemWrEn(DataMemWrEn), .ProcessorDataIn(ProcessorDataIn),
    .done(done), .loadEn(loadEn), .loadAddr(loadAddr), .loadData(loadData),
    .dumpData(dumpData), .dumpAddr(dumpAddr), .dumpValid(dumpValid),
    .dumpReady(dumpReady), .dumpLast(dumpLast), .busy(busy), .dumpDone(dumpDone)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    loadEn = 1'b1; loadAddr = a; loadData = d;
    tick();
    loadEn = 1'b0;
  endtask

  task automatic test_reset();
    #1 rstN = 1'b0;
    #2;
    n_cmp++; if (ProcessorDataIn !== '0) begin n_bad++; $display("FAIL reset_pdi got %h want 0", ProcessorDataIn); end
    n_cmp++; if (dumpData !== '0 || dumpAddr !== '0) begin n_bad++; $display("FAIL reset_dump_bus data %h addr %h want 0", dumpData, dumpAddr); end
    n_cmp++; if ({dumpValid, dumpLast, busy, dumpDone} !== 4'b0) begin n_bad++; $display("FAIL reset_ctrl got %b want 0000", {dumpValid, dumpLast, busy, dumpDone}); end
    tick(); tick();
    n_cmp++; if ({dumpValid, busy, dumpDone} !== 3'b0) begin n_bad++; $display("FAIL reset_hold got %b want 000", {dumpValid, busy, dumpDone}); end
    rstN = 1'b1;
    tick();
  endtask

  task automatic test_preload_read();
    load_word(12'd6, 36'd5);
    load_word(12'd7, 36'h123456789);
    dataMemAddr = 12'd6;
    tick();
    n_cmp++; if (ProcessorDataIn !== 36'd5) begin n_bad++; $display("FAIL read_addr6 got %h want 5", ProcessorDataIn); end
    dataMemAddr = 12'd7;
    #1;
    n_cmp++; if (ProcessorDataIn !== 36'd5) begin n_bad++; $display("FAIL read_latency_early got %h want 5", ProcessorDataIn); end
    tick();
    n_cmp++; if (ProcessorDataIn !== 36'h123456789) begin n_bad++; $display("FAIL read_addr7 got %h want 123456789", ProcessorDataIn); end
  endtask

  task automatic test_read_during_write();
    load_word(12'd20, 36'd0);
    dataMemAddr = 12'd20; DataMemWrEn = 1'b1; ProcessorDataOut = 36'hABC;
    tick();
    DataMemWrEn = 1'b0;
    n_cmp++; if (ProcessorDataIn !== 36'd0) begin n_bad++; $display("FAIL rdw_old got %h want 0", ProcessorDataIn); end
    tick();
    n_cmp++; if (ProcessorDataIn !== 36'hABC) begin n_bad++; $display("FAIL rdw_new got %h want abc", ProcessorDataIn); end
  endtask

  task automatic test_load_priority();
    load_word(12'd31, 36'd7);
    loadEn = 1'b1; loadAddr = 12'd30; loadData = 36'd111;
    DataMemWrEn = 1'b1; dataMemAddr = 12'd31; ProcessorDataOut = 36'd222;
    tick();
    loadEn = 1'b0; DataMemWrEn = 1'b0;
    tick();
    n_cmp++; if (ProcessorDataIn !== 36'd7) begin n_bad++; $display("FAIL prio_proc_blocked got %0d want 7", ProcessorDataIn); end
    dataMemAddr = 12'd30;
    tick();
    n_cmp++; if (ProcessorDataIn !== 36'd111) begin n_bad++; $display("FAIL prio_load_done got %0d want 111", ProcessorDataIn); end
  endtask

  task automatic test_dump_basic();
    int  beats;
    bit  got_last;
    beats = 0; got_last = 1'b0;
    load_word(12'd5, 36'd100);
    load_word(12'd8, 36'd103);
    for (int i = 0; i < 4; i++) load_word(AW'(100 + i), DW'(i + 1));
    dataMemAddr = 12'd7;
    dumpReady = 1'b1;
    done = 1'b1;
    tick();
    done = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL dump_busy_start got %b want 1", busy); end
    for (int c = 0; c < 40 && !got_last; c++) begin
      if (dumpValid) begin
        n_cmp++; if (dumpAddr !== AW'(100 + beats)) begin n_bad++; $display("FAIL dump_addr beat %0d got %0d want %0d", beats, dumpAddr, 100 + beats); end
        n_cmp++; if (dumpData !== DW'(beats + 1)) begin n_bad++; $display("FAIL dump_data beat %0d got %0d want %0d", beats, dumpData, beats + 1); end
        n_cmp++; if (dumpLast !== (beats == 3)) begin n_bad++; $display("FAIL dump_last beat %0d got %b want %b", beats, dumpLast, beats == 3); end
        if (dumpLast) got_last = 1'b1;
        beats++;
      end
      tick();
    end
    n_cmp++; if (beats != 4 || !got_last) begin n_bad++; $display("FAIL dump_beat_count got %0d last %b want 4 last 1", beats, got_last); end
    n_cmp++; if ({dumpDone, busy, dumpValid} !== 3'b100) begin n_bad++; $display("FAIL dump_done_pulse got %b want 100", {dumpDone, busy, dumpValid}); end
    tick();
    n_cmp++; if ({dumpDone, busy} !== 2'b00) begin n_bad++; $display("FAIL dump_done_end got %b want 00", {dumpDone, busy}); end
  endtask

  task automatic test_stall();
    bit  pat [4];
    int  beats;
    bit  saw_done;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    beats = 0; saw_done = 1'b0;
    dataMemAddr = 12'd7;
    dumpReady = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;
    dataMemAddr = 12'd100;
    loadEn = 1'b1; loadAddr = 12'd103; loadData = 36'd77;
    for (int c = 0; c < 80 && !saw_done; c++) begin
      if (!busy) loadEn = 1'b0;
      dumpReady = pat[c % 4];
      if (dumpValid) begin
        n_cmp++; if (dumpAddr !== AW'(100 + beats) || dumpData !== DW'(beats + 1)) begin n_bad++; $display("FAIL stall_beat %0d got addr %0d data %0d want %0d %0d", beats, dumpAddr, dumpData, 100 + beats, beats + 1); end
        if (dumpReady) beats++;
      end
      if (dumpDone) begin
        saw_done = 1'b1;
        n_cmp++; if (ProcessorDataIn !== 36'h123456789) begin n_bad++; $display("FAIL stall_pdi_hold got %h want 123456789", ProcessorDataIn); end
      end else begin
        tick();
      end
    end
    loadEn = 1'b0;
    n_cmp++; if (beats != 4 || !saw_done) begin n_bad++; $display("FAIL stall_count got %0d done %b want 4 done 1", beats, saw_done); end
    dumpReady = 1'b0;
    dataMemAddr = 12'd103;
    tick(); tick();
    n_cmp++; if (ProcessorDataIn !== 36'd4) begin n_bad++; $display("FAIL busy_write_ignored got %0d want 4", ProcessorDataIn); end
  endtask

  task automatic test_empty_region();
    load_word(12'd5, 36'd50);
    load_word(12'd8, 36'd40);
    dumpReady = 1'b1;
    done = 1'b1;
    tick();
    done = 1'b0;
    n_cmp++; if ({dumpDone, dumpValid} !== 2'b00) begin n_bad++; $display("FAIL empty_c1 got %b want 00", {dumpDone, dumpValid}); end
    tick();
    n_cmp++; if ({dumpDone, dumpValid} !== 2'b00) begin n_bad++; $display("FAIL empty_c2 got %b want 00", {dumpDone, dumpValid}); end
    tick();
    n_cmp++; if ({dumpDone, dumpValid, busy} !== 3'b100) begin n_bad++; $display("FAIL empty_done got %b want 100", {dumpDone, dumpValid, busy}); end
    done = 1'b1;
    tick();
    done = 1'b0;
    n_cmp++; if ({busy, dumpDone} !== 2'b00) begin n_bad++; $display("FAIL finish_done_ignored got %b want 00", {busy, dumpDone}); end
    tick();
    n_cmp++; if ({busy, dumpValid} !== 2'b00) begin n_bad++; $display("FAIL finish_done_idle got %b want 00", {busy, dumpValid}); end
  endtask

  task automatic test_reset_mid_dump();
    int beats;
    bit restarted;
    bit saw_done;
    beats = 0; restarted = 1'b0; saw_done = 1'b0;
    load_word(12'd5, 36'd100);
    load_word(12'd8, 36'd103);
    dumpReady = 1'b1;
    done = 1'b1;
    tick();
    done = 1'b0;
    for (int c = 0; c < 30 && beats < 2; c++) begin
      if (dumpValid) beats++;
      if (beats < 2) tick();
    end
    n_cmp++; if (beats != 2) begin n_bad++; $display("FAIL abort_reach_beat2 got %0d want 2", beats); end
    rstN = 1'b0;
    #1;
    n_cmp++; if ({dumpValid, busy, dumpLast, dumpDone} !== 4'b0 || dumpData !== '0 || dumpAddr !== '0 || ProcessorDataIn !== '0) begin
      n_bad++; $display("FAIL abort_outputs got v%b b%b data %h addr %h pdi %h want all 0", dumpValid, busy, dumpData, dumpAddr, ProcessorDataIn);
    end
    tick(); tick();
    n_cmp++; if ({dumpValid, dumpDone} !== 2'b00) begin n_bad++; $display("FAIL abort_held got %b want 00", {dumpValid, dumpDone}); end
    rstN = 1'b1;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    for (int c = 0; c < 40 && !saw_done; c++) begin
      if (dumpValid && !restarted) begin
        restarted = 1'b1;
        n_cmp++; if (dumpAddr !== 12'd100 || dumpData !== 36'd1) begin n_bad++; $display("FAIL restart_first got addr %0d data %0d want 100 1", dumpAddr, dumpData); end
      end
      if (dumpDone) saw_done = 1'b1;
      tick();
    end
    n_cmp++; if (!restarted || !saw_done) begin n_bad++; $display("FAIL restart_complete got beat %b done %b want 1 1", restarted, saw_done); end
  endtask

  initial begin
    test_reset();
    test_preload_read();
    test_read_during_write();
    test_load_priority();
    test_dump_basic();
    test_stall();
    test_empty_region();
    test_reset_mid_dump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Synthesizable data-memory responder on the far side of the multi_core_processor data port.
- Serves processor reads and writes with single-cycle registered read latency.
- Accepts host preload writes while the processor is idle.
- On the processor's done pulse, autonomously reads the result-matrix bounds from fixed memory locations and streams that region out over a valid/ready dump port.
- Replaces the bench-side behavioural memory and $writememb dump.

Parameters:
- REG_WIDTH, 12, width of one core lane.
- CORE_COUNT, 3, lanes per memory word; DATA_MEM_WIDTH = REG_WIDTH*CORE_COUNT.
- DATA_MEM_DEPTH, 4096, words of storage.
- DATA_MEM_ADDR_WIDTH, 12, $clog2(DATA_MEM_DEPTH).
- R_START_LOC, 5, address holding the R start address (lane 0).
- R_END_LOC, 8, address holding the R end address (lane 0).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rstN  in  1  asynchronous active-low reset.
- dataMemAddr  in  DATA_MEM_ADDR_WIDTH  processor read/write address.
- ProcessorDataOut  in  DATA_MEM_WIDTH  processor write data.
- DataMemWrEn  in  1  processor write strobe.
- ProcessorDataIn  out  DATA_MEM_WIDTH  registered read data to processor.
- done  in  1  processor completion pulse; starts dump.
- loadEn  in  1  host preload write strobe.
- loadAddr  in  DATA_MEM_ADDR_WIDTH  host preload address.
- loadData  in  DATA_MEM_WIDTH  host preload data.
- dumpData  out  DATA_MEM_WIDTH  dump beat payload.
- dumpAddr  out  DATA_MEM_ADDR_WIDTH  source address of current beat.
- dumpValid  out  1  beat valid.
- dumpReady  in  1  sink accepts beat.
- dumpLast  out  1  final beat of region.
- busy  out  1  dump in progress.
- dumpDone  out  1  one-cycle pulse at dump end.

Behaviour:
- Reset:
  - ProcessorDataIn, dumpData and dumpAddr are 0; dumpValid, dumpLast, busy and dumpDone are 0; FSM is in IDLE.
  - Memory contents are not cleared.
  - Reset asserted mid-dump aborts the dump immediately with no further beats.
- Processor port (IDLE only):
  - Every cycle, ProcessorDataIn <= mem[dataMemAddr], a 1-cycle latency.
  - Read-during-write to the same address returns the old data (read-first).
  - DataMemWrEn=1 writes ProcessorDataOut to mem[dataMemAddr].
- Load port (IDLE only): loadEn=1 writes loadData to mem[loadAddr]. If loadEn and DataMemWrEn are both 1 in the same cycle, only the load write occurs.
- FSM states: IDLE -> RD_START -> RD_END -> RD_WORD -> PRESENT -> (RD_WORD | FINISH) -> IDLE.
  - IDLE: done=1 -> RD_START; busy=1 from the next cycle.
  - RD_START: issue read of R_START_LOC; latch lane 0 (bits REG_WIDTH-1:0) as startAddr.
  - RD_END: same for R_END_LOC, latched as endAddr.
    - If endAddr < startAddr, go to FINISH with zero beats.
    - Otherwise set ptr = startAddr and go to RD_WORD.
  - RD_WORD: issue read of mem[ptr]; next state PRESENT.
  - PRESENT:
    - Output dumpValid=1, dumpData = the word, dumpAddr = ptr, dumpLast = (ptr==endAddr).
    - Hold all of these stable while dumpReady=0.
    - On dumpReady=1: if last, go to FINISH; else ptr+1 and go to RD_WORD.
  - FINISH: dumpDone=1 for one cycle, busy=0, return to IDLE.
- Throughput and range: one beat per 2 cycles minimum; the region is inclusive.
- Address arithmetic: ptr is DATA_MEM_ADDR_WIDTH+1 bits internally, so endAddr = DATA_MEM_DEPTH-1 terminates without wrap. Bounds wider than the address are truncated to DATA_MEM_ADDR_WIDTH bits.
- While busy:
  - DataMemWrEn, loadEn and done are ignored.
  - ProcessorDataIn holds its last value.
- done while in FINISH is ignored; a new dump needs done in IDLE.

Optional Feature:
- DUMP_LANE_SPLIT_EN defined:
  - Each word is emitted as CORE_COUNT beats, highest lane first (lane CORE_COUNT-1 down to 0).
  - Payload sits in dumpData[REG_WIDTH-1:0]; upper bits are 0.
  - dumpAddr repeats for all lanes of a word.
  - dumpLast is only on lane 0 of endAddr.
  - Each lane beat is presented in PRESENT; the memory is re-read only on word change.
- DUMP_LANE_SPLIT_EN undefined: one full-width beat per word, as above.

Test Plan:
- Preload mem[7]=36'h123456789 via loadEn, then processor read of addr 7 -> ProcessorDataIn=36'h123456789 exactly one cycle after the address is presented.
- Same-cycle processor write and read of addr 20: old 0 then new 36'hABC -> ProcessorDataIn is 0 in the first read cycle and 36'hABC in the next.
- mem[5]=100, mem[8]=103, mem[100..103]=1,2,3,4, done pulse, dumpReady=1 -> 4 beats with dumpAddr 100..103, data 1..4, dumpLast on the 4th, dumpDone one cycle later, busy low afterwards.
- Same setup with dumpReady toggling 1-0-0-1 -> beats never dropped or duplicated; dumpData and dumpAddr stable while stalled.
- mem[5]=50, mem[8]=40 -> no dumpValid; dumpDone 3 cycles after done.
- Reset pulsed after the 2nd beat of a 4-beat dump -> all outputs 0 immediately; a later done restarts from the start address.
